pipe_ctrl_unit: RTL and testbench

- Pipelined successor to the single-cycle MIPS control decoder.
- Decodes the instruction in ID and registers the full control bundle into the ID/EX stage.
- Detects load-use hazards and stalls ID for them.
- Applies branch flushes.
- Sequences a multi-cycle MULT/DIV unit with a busy counter, stalling dependent instructions until it finishes.

---
 rtl/pipe_ctrl_unit_if.sv | 40 ++++
 rtl/pipe_ctrl_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_unit_if.sv
// ID-stage instruction fields and hazard inputs in, with the registered ID/EX control bundle and stall/flush out.
// The slave modport is the control unit; the master modport is the surrounding pipeline.
interface pipe_ctrl_unit_if #(
  parameter int REG_AW = 5
);
  logic              valid_D;
  logic [5:0]        opcode_D;
  logic [5:0]        funct_D;
  logic [REG_AW-1:0] rs_D;
  logic [REG_AW-1:0] rt_D;
  logic [REG_AW-1:0] rd_D;
  logic              branch_taken_E;

  logic              stall_D;
  logic              flush_D;
  logic              valid_E;
  logic              rfwe_E;
  logic              mtorf_E;
  logic              dmwe_E;
  logic              aluinsel_E;
  logic              branch_E;
  logic              jump_E;
  logic [3:0]        alusel_E;
  logic [REG_AW-1:0] wreg_E;
  logic              md_start_E;
  logic              md_busy;
  logic              illegal_E;

  modport slave (
    input  valid_D, opcode_D, funct_D, rs_D, rt_D, rd_D, branch_taken_E,
    output stall_D, flush_D, valid_E, rfwe_E, mtorf_E, dmwe_E, aluinsel_E,
           branch_E, jump_E, alusel_E, wreg_E, md_start_E, md_busy, illegal_E
  );

  modport master (
    output valid_D, opcode_D, funct_D, rs_D, rt_D, rd_D, branch_taken_E,
    input  stall_D, flush_D, valid_E, rfwe_E, mtorf_E, dmwe_E, aluinsel_E,
           branch_E, jump_E, alusel_E, wreg_E, md_start_E, md_busy, illegal_E
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control: decodes ID into the ID/EX control register (1 cycle), stalls ID on load-use
// and MULT/DIV-busy hazards, bubbles on branch flush, and times the multi-cycle MULT/DIV unit.
module pipe_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int MD_LATENCY = 32,
  parameter int ENABLE_MD  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_ctrl_unit_if.slave  bus
);

  localparam logic [7:0] MD_LAT = 8'(MD_LATENCY);
  localparam bit         MD_EN  = (ENABLE_MD != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // Decoded ID bundle
  logic              w_rfwe;
  logic              w_mtorf;
  logic              w_dmwe;
  logic              w_aluinsel;
  logic              w_branch;
  logic              w_jump;
  logic [3:0]        w_alusel;
  logic [REG_AW-1:0] w_wreg;
  logic              w_illegal;
  logic              w_md_op;
  logic              w_md_rd;
  logic              w_rt_src;

  // Hazard and issue control
  logic              w_load_use;
  logic              w_md_hazard;
  logic              w_stall;
  logic              w_load;
  logic              w_launch;
  logic              w_md_busy;

  // ID/EX register
  logic              r_valid_E;
  logic              r_rfwe_E;
  logic              r_mtorf_E;
  logic              r_dmwe_E;
  logic              r_aluinsel_E;
  logic              r_branch_E;
  logic              r_jump_E;
  logic [3:0]        r_alusel_E;
  logic [REG_AW-1:0] r_wreg_E;
  logic              r_illegal_E;
  logic              r_md_start_E;
  logic [7:0]        r_md_cnt;

  always_comb begin
    w_rfwe     = 1'b0;
    w_mtorf    = 1'b0;
    w_dmwe     = 1'b0;
    w_aluinsel = 1'b0;
    w_branch   = 1'b0;
    w_jump     = 1'b0;
    w_alusel   = 4'b0000;
    w_wreg     = '0;
    w_illegal  = 1'b0;
    w_md_op    = 1'b0;
    w_md_rd    = 1'b0;

    case (bus.opcode_D)
      OP_RTYPE: begin
        w_rfwe = 1'b1;
        w_wreg = bus.rd_D;
        case (bus.funct_D)
          FN_ADD:  w_alusel = 4'b0000;
          FN_SUB:  w_alusel = 4'b0001;
          FN_AND:  w_alusel = 4'b0111;
          FN_OR:   w_alusel = 4'b1000;
          FN_SLT:  w_alusel = 4'b1001;
          FN_SLL:  w_alusel = 4'b0010;
          FN_SLLV: w_alusel = 4'b0100;
          FN_SRAV: w_alusel = 4'b1011;
          FN_MFHI: begin
            w_alusel  = 4'b1100;
            w_md_rd   = MD_EN;
            w_illegal = !MD_EN;
          end
          FN_MFLO: begin
            w_alusel  = 4'b1101;
            w_md_rd   = MD_EN;
            w_illegal = !MD_EN;
          end
          FN_MULT, FN_DIV: begin
            w_rfwe    = 1'b0;
            w_md_op   = MD_EN;
            w_illegal = !MD_EN;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        w_rfwe     = 1'b1;
        w_mtorf    = 1'b1;
        w_aluinsel = 1'b1;
        w_wreg     = bus.rt_D;
      end
      OP_SW: begin
        w_dmwe     = 1'b1;
        w_aluinsel = 1'b1;
      end
      OP_BEQ: begin
        w_branch = 1'b1;
        w_alusel = 4'b0001;
      end
      OP_J: w_jump = 1'b1;
      OP_ADDI, OP_ORI, OP_SLTI: begin
        w_rfwe     = 1'b1;
        w_aluinsel = 1'b1;
        w_wreg     = bus.rt_D;
        w_alusel   = (bus.opcode_D == OP_ORI)  ? 4'b1000 :
                     (bus.opcode_D == OP_SLTI) ? 4'b1001 : 4'b0000;
      end
      default: w_illegal = 1'b1;
    endcase

    // An unrecognised instruction must not touch any architectural state.
    if (w_illegal) begin
      w_rfwe     = 1'b0;
      w_mtorf    = 1'b0;
      w_dmwe     = 1'b0;
      w_aluinsel = 1'b0;
      w_branch   = 1'b0;
      w_jump     = 1'b0;
      w_alusel   = 4'b0000;
      w_wreg     = '0;
      w_md_op    = 1'b0;
      w_md_rd    = 1'b0;
    end

    if (w_wreg == '0) begin
      w_rfwe = 1'b0;
    end
  end

  assign w_rt_src = (bus.opcode_D == OP_RTYPE) || (bus.opcode_D == OP_SW) ||
                    (bus.opcode_D == OP_BEQ);

  assign w_md_busy   = (r_md_cnt != 8'd0);
  assign w_load_use  = r_mtorf_E && r_valid_E && (r_wreg_E != '0) &&
                       ((r_wreg_E == bus.rs_D) || (w_rt_src && (r_wreg_E == bus.rt_D)));
  assign w_md_hazard = w_md_busy && (w_md_op || w_md_rd);

  // A taken branch squashes ID, so a hazard on the squashed instruction must not hold the PC.
  assign w_stall  = bus.valid_D && !bus.branch_taken_E && (w_load_use || w_md_hazard);
  assign w_load   = bus.valid_D && !bus.branch_taken_E && !w_stall;
  assign w_launch = w_load && w_md_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_E    <= 1'b0;
      r_rfwe_E     <= 1'b0;
      r_mtorf_E    <= 1'b0;
      r_dmwe_E     <= 1'b0;
      r_aluinsel_E <= 1'b0;
      r_branch_E   <= 1'b0;
      r_jump_E     <= 1'b0;
      r_alusel_E   <= 4'b0000;
      r_wreg_E     <= '0;
      r_illegal_E  <= 1'b0;
      r_md_start_E <= 1'b0;
      r_md_cnt     <= 8'd0;
    end else begin
      if (w_load) begin
        r_valid_E    <= 1'b1;
        r_rfwe_E     <= w_rfwe;
        r_mtorf_E    <= w_mtorf;
        r_dmwe_E     <= w_dmwe;
        r_aluinsel_E <= w_aluinsel;
        r_branch_E   <= w_branch;
        r_jump_E     <= w_jump;
        r_alusel_E   <= w_alusel;
        r_wreg_E     <= w_wreg;
        r_illegal_E  <= w_illegal;
      end else begin
        r_valid_E    <= 1'b0;
        r_rfwe_E     <= 1'b0;
        r_mtorf_E    <= 1'b0;
        r_dmwe_E     <= 1'b0;
        r_aluinsel_E <= 1'b0;
        r_branch_E   <= 1'b0;
        r_jump_E     <= 1'b0;
        r_alusel_E   <= 4'b0000;
        r_wreg_E     <= '0;
        r_illegal_E  <= 1'b0;
      end

      r_md_start_E <= w_launch;
      if (w_launch) begin
        r_md_cnt <= MD_LAT;
      end else if (r_md_cnt != 8'd0) begin
        r_md_cnt <= r_md_cnt - 8'd1;
      end
    end
  end

  assign bus.stall_D    = w_stall;
  assign bus.flush_D    = bus.branch_taken_E;
  assign bus.valid_E    = r_valid_E;
  assign bus.rfwe_E     = r_rfwe_E;
  assign bus.mtorf_E    = r_mtorf_E;
  assign bus.dmwe_E     = r_dmwe_E;
  assign bus.aluinsel_E = r_aluinsel_E;
  assign bus.branch_E   = r_branch_E;
  assign bus.jump_E     = r_jump_E;
  assign bus.alusel_E   = r_alusel_E;
  assign bus.wreg_E     = r_wreg_E;
  assign bus.md_start_E = r_md_start_E;
  assign bus.md_busy    = w_md_busy;
  assign bus.illegal_E  = r_illegal_E;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: one MULT/DIV-enabled instance (latency 4) and one with MULT/DIV disabled,
// both fed the same ID stream.
module tb_pipe_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic       valid_D;
  logic [5:0] opcode_D;
  logic [5:0] funct_D;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic [4:0] rd_D;
  logic       branch_taken_E;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  pipe_ctrl_unit_if #(.REG_AW(5)) if0 ();
  pipe_ctrl_unit_if #(.REG_AW(5)) if1 ();

  assign if0.valid_D        = valid_D;
  assign if0.opcode_D       = opcode_D;
  assign if0.funct_D        = funct_D;
  assign if0.rs_D           = rs_D;
  assign if0.rt_D           = rt_D;
  assign if0.rd_D           = rd_D;
  assign if0.branch_taken_E = branch_taken_E;

  assign if1.valid_D        = valid_D;
  assign if1.opcode_D       = opcode_D;
  assign if1.funct_D        = funct_D;
  assign if1.rs_D           = rs_D;
  assign if1.rt_D           = rt_D;
  assign if1.rd_D           = rd_D;
  assign if1.branch_taken_E = branch_taken_E;

  pipe_ctrl_unit #(.REG_AW(5), .MD_LATENCY(4), .ENABLE_MD(1)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  pipe_ctrl_unit #(.REG_AW(5), .MD_LATENCY(4), .ENABLE_MD(0)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    valid_D  = 1'b1;
    opcode_D = op;
    funct_D  = fn;
    rs_D     = rs;
    rt_D     = rt;
    rd_D     = rd;
    #1;
  endtask

  task automatic idle();
    valid_D = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] enables0();
    return 32'({if0.rfwe_E, if0.mtorf_E, if0.dmwe_E, if0.aluinsel_E, if0.branch_E, if0.jump_E});
  endfunction

  initial begin
    rst_n          = 1'b0;
    valid_D        = 1'b0;
    opcode_D       = 6'd0;
    funct_D        = 6'd0;
    rs_D           = 5'd0;
    rt_D           = 5'd0;
    rd_D           = 5'd0;
    branch_taken_E = 1'b0;

    #12;
    chk("rst_valid_E", 32'(if0.valid_E), 0);
    chk("rst_md_busy", 32'(if0.md_busy), 0);
    chk("rst_enables", enables0(), 0);
    chk("rst_wreg_E", 32'(if0.wreg_E), 0);
    rst_n = 1'b1;

    // add rd=3, lw rt=4, sw back to back
    step();
    drv(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
    step();
    chk("add_valid_E", 32'(if0.valid_E), 1);
    chk("add_alusel", 32'(if0.alusel_E), 0);
    chk("add_rfwe", 32'(if0.rfwe_E), 1);
    chk("add_wreg", 32'(if0.wreg_E), 3);
    drv(6'b100011, 6'd0, 5'd1, 5'd4, 5'd0);
    step();
    chk("lw_mtorf", 32'(if0.mtorf_E), 1);
    chk("lw_wreg", 32'(if0.wreg_E), 4);
    chk("lw_aluinsel", 32'(if0.aluinsel_E), 1);
    drv(6'b101011, 6'd0, 5'd1, 5'd6, 5'd0);
    chk("sw_nostall", 32'(if0.stall_D), 0);
    step();
    chk("sw_dmwe", 32'(if0.dmwe_E), 1);
    chk("sw_rfwe", 32'(if0.rfwe_E), 0);
    chk("sw_wreg", 32'(if0.wreg_E), 0);

    // load-use on rs=5
    drv(6'b100011, 6'd0, 5'd1, 5'd5, 5'd0);
    step();
    drv(6'b000000, 6'b100000, 5'd5, 5'd7, 5'd8);
    chk("lu_stall", 32'(if0.stall_D), 1);
    step();
    chk("lu_bubble", 32'(if0.valid_E), 0);
    chk("lu_stall_clear", 32'(if0.stall_D), 0);
    step();
    chk("lu_issue_valid", 32'(if0.valid_E), 1);
    chk("lu_issue_wreg", 32'(if0.wreg_E), 8);

    // lw to r0 never creates a hazard
    drv(6'b100011, 6'd0, 5'd1, 5'd0, 5'd0);
    step();
    chk("lw0_rfwe", 32'(if0.rfwe_E), 0);
    drv(6'b000000, 6'b100000, 5'd0, 5'd0, 5'd9);
    chk("lw0_nostall", 32'(if0.stall_D), 0);
    step();
    chk("lw0_add_valid", 32'(if0.valid_E), 1);
    chk("lw0_add_wreg", 32'(if0.wreg_E), 9);

    // mult then dependent mflo
    drv(6'b000000, 6'b011000, 5'd2, 5'd3, 5'd0);
    chk("mult_nostall", 32'(if0.stall_D), 0);
    step();
    chk("mult_start", 32'(if0.md_start_E), 1);
    chk("mult_busy", 32'(if0.md_busy), 1);
    chk("mult_rfwe", 32'(if0.rfwe_E), 0);
    drv(6'b000000, 6'b010010, 5'd0, 5'd0, 5'd10);
    chk("mflo_stall", 32'(if0.stall_D), 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("md_start_once", 32'(if0.md_start_E), 0);
      chk("md_busy_hold", 32'(if0.md_busy), 1);
      chk("mflo_stall_hold", 32'(if0.stall_D), 1);
      chk("mflo_bubble", 32'(if0.valid_E), 0);
    end
    step();
    chk("md_busy_drop", 32'(if0.md_busy), 0);
    chk("mflo_unstall", 32'(if0.stall_D), 0);
    step();
    chk("mflo_valid", 32'(if0.valid_E), 1);
    chk("mflo_alusel", 32'(if0.alusel_E), 13);
    chk("mflo_wreg", 32'(if0.wreg_E), 10);
    chk("mflo_rfwe", 32'(if0.rfwe_E), 1);

    // illegal opcode
    drv(6'b111111, 6'd0, 5'd1, 5'd2, 5'd3);
    step();
    chk("ill_flag", 32'(if0.illegal_E), 1);
    chk("ill_valid", 32'(if0.valid_E), 1);
    chk("ill_enables", enables0(), 0);

    // beq, ori
    drv(6'b000100, 6'd0, 5'd1, 5'd2, 5'd0);
    step();
    chk("beq_branch", 32'(if0.branch_E), 1);
    chk("beq_alusel", 32'(if0.alusel_E), 1);
    chk("beq_illegal", 32'(if0.illegal_E), 0);
    drv(6'b001101, 6'd0, 5'd1, 5'd6, 5'd0);
    step();
    chk("ori_alusel", 32'(if0.alusel_E), 8);
    chk("ori_aluinsel", 32'(if0.aluinsel_E), 1);
    chk("ori_wreg", 32'(if0.wreg_E), 6);

    // div on both instances
    drv(6'b000000, 6'b011010, 5'd2, 5'd3, 5'd0);
    step();
    chk("nomd_illegal", 32'(if1.illegal_E), 1);
    chk("nomd_start", 32'(if1.md_start_E), 0);
    chk("nomd_busy", 32'(if1.md_busy), 0);
    chk("div_start", 32'(if0.md_start_E), 1);
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("div_done", 32'(if0.md_busy), 0);

    // branch flush over a stalled load-use add, then over a pending mult
    drv(6'b100011, 6'd0, 5'd1, 5'd5, 5'd0);
    step();
    drv(6'b000000, 6'b100000, 5'd5, 5'd7, 5'd8);
    chk("fl_prestall", 32'(if0.stall_D), 1);
    branch_taken_E = 1'b1;
    #1;
    chk("fl_flush", 32'(if0.flush_D), 1);
    chk("fl_nostall", 32'(if0.stall_D), 0);
    step();
    chk("fl_bubble", 32'(if0.valid_E), 0);
    chk("fl_mtorf", 32'(if0.mtorf_E), 0);
    drv(6'b000000, 6'b011000, 5'd2, 5'd3, 5'd0);
    step();
    chk("fl_md_nostart", 32'(if0.md_start_E), 0);
    chk("fl_md_notbusy", 32'(if0.md_busy), 0);
    branch_taken_E = 1'b0;
    #1;
    chk("fl_flush_off", 32'(if0.flush_D), 0);

    // reset while mult counter is 2
    step();
    chk("rm_start", 32'(if0.md_start_E), 1);
    drv(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3);
    step();
    step();
    chk("rm_busy_pre", 32'(if0.md_busy), 1);
    chk("rm_valid_pre", 32'(if0.valid_E), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_busy", 32'(if0.md_busy), 0);
    chk("rm_valid", 32'(if0.valid_E), 0);
    chk("rm_rfwe", 32'(if0.rfwe_E), 0);
    chk("rm_wreg", 32'(if0.wreg_E), 0);
    chk("rm_start_off", 32'(if0.md_start_E), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
